// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: double-dabble BCD conversion,
// digit scanning, leading-zero blanking, decimal points and blink.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int BIN_W        = 14,
  parameter int DIGIT_CYCLES = 262144,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int RW    =
    DIGIT_CYCLES > 1 ? $clog2(DIGIT_CYCLES) : 1;
  localparam int KW    =
    BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  localparam int IW    =
    NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RW-1:0] REF_MAX = RW'(DIGIT_CYCLES - 1);
  localparam logic [KW-1:0] BLK_MAX = KW'(BLINK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SH_MAX  = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [CW-1:0]     sh_cnt;
  logic              ovf_acc;
  logic [BCD_W-1:0]  disp;

  logic [RW-1:0]     ref_cnt;
  logic [IW-1:0]     idx;
  logic [KW-1:0]     blk_cnt;
  logic              phase;

  logic [3:0]            digit;
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_above;
  logic                  lit;
  logic [6:0]            seg_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  logic                  dp_nx;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 on every BCD nibble ahead of the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] =
          sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      sh_cnt   <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            sr      <= {{BCD_W{1'b0}}, value};
            sh_cnt  <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= {sr_adj[SR_W-2:0], 1'b0};
          ovf_acc <= ovf_acc | sr_adj[SR_W-1];
          sh_cnt  <= sh_cnt + 1'b1;
          if (sh_cnt == SH_MAX)
            state <= DONE;
        end
        DONE: begin
          disp     <= sr[SR_W-1 -: BCD_W];
          overflow <= ovf_acc;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (!blink_en) begin
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else if (blk_cnt == BLK_MAX) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  // lz[i]: digit i and everything above it are zero
  always_comb begin
    digit      = disp[4*int'(idx) +: 4];
    lz         = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above &
                   (disp[4*i +: 4] == 4'd0);
      lz[i]      = zero_above;
    end
    lit = ~blink_en | phase;
    if (overflow)
      seg_nx = 7'b1111110;
    else if (blank_lz && lz[idx])
      seg_nx = 7'b1111111;
    else
      seg_nx = dec7(digit);
    an_nx = '1;
    if (lit)
      an_nx[idx] = 1'b0;
    dp_nx = lit ? ~dp_mask[idx] : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode <= '1;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      anode <= an_nx;
      seg   <= seg_nx;
      dp    <= dp_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scenario bench for seg7_scan_ctrl with a queue of expected
// display contents pushed at load and popped after conversion.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int BW = 14;
  localparam int DC = 4;
  localparam int BC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;
  logic          blank_lz = 1'b0;
  logic [N-1:0]  dp_mask = '0;
  logic          blink_en = 1'b0;
  logic          busy;
  logic          overflow;
  logic [N-1:0]  anode;
  logic [6:0]    seg;
  logic          dp;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .BIN_W       (BW),
    .DIGIT_CYCLES(DC),
    .BLINK_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .value   (value),
    .blank_lz(blank_lz),
    .dp_mask (dp_mask),
    .blink_en(blink_en),
    .busy    (busy),
    .overflow(overflow),
    .anode   (anode),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              ovf;
    logic [N-1:0][6:0] segs;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b0000001;
      1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;
      3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;
      5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;
      7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int v, input bit blz);
    exp_t e;
    int   dig[N];
    int   dv;
    bit   hz;
    dv = v;
    for (int i = 0; i < N; i++) begin
      dig[i] = dv % 10;
      dv = dv / 10;
    end
    e.ovf = (v > 9999);
    hz = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      hz = hz && (dig[i] == 0);
      if (e.ovf)
        e.segs[i] = 7'b1111110;
      else if (blz && hz && i != 0)
        e.segs[i] = 7'b1111111;
      else
        e.segs[i] = seg_of(dig[i]);
    end
    return e;
  endfunction

  task automatic run_load(input int v, input int late_v,
                          output int nbusy, output bit to);
    @(negedge clk);
    value = BW'(v);
    load  = 1'b1;
    nbusy = 0;
    to    = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      load = (k == 2 && late_v >= 0);
      if (k == 2 && late_v >= 0)
        value = BW'(late_v);
      if (busy) nbusy++;
      else begin
        to = 1'b0;
        break;
      end
    end
    load = 1'b0;
  endtask

  task automatic capture(output logic [N-1:0][6:0] seen,
                         output logic [N-1:0] hit,
                         output int bad);
    seen = '1;
    hit  = '0;
    bad  = 0;
    repeat (N * DC) begin
      @(negedge clk);
      if ($countones(~anode) != 1) bad++;
      else
        for (int i = 0; i < N; i++)
          if (!anode[i]) begin
            seen[i] = seg;
            hit[i]  = 1'b1;
          end
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] ea;
    #1 reset = 1'b1;
    #2;
    tests++;
    if (anode !== 4'b1111) begin
      fails++;
      $display("FAIL rst_anode: got %b want 1111", anode);
    end
    tests++;
    if (seg !== 7'b1111111) begin
      fails++;
      $display("FAIL rst_seg: got %b want 1111111", seg);
    end
    tests++;
    if (dp !== 1'b1) begin
      fails++;
      $display("FAIL rst_dp: got %b want 1", dp);
    end
    tests++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags: got busy=%b ovf=%b want 0 0",
               busy, overflow);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= N * DC; k++) begin
      @(negedge clk);
      ea = ~(4'b0001 << ((k - 1) / DC));
      tests++;
      if (anode !== ea) begin
        fails++;
        $display("FAIL scan_anode[%0d]: got %b want %b",
                 k, anode, ea);
      end
      tests++;
      if (seg !== 7'b0000001) begin
        fails++;
        $display("FAIL scan_seg[%0d]: got %b want 0000001",
                 k, seg);
      end
    end
  endtask

  task automatic test_convert(input int v, input bit blz);
    exp_t              e;
    int                nb;
    bit                to;
    logic [N-1:0][6:0] seen;
    logic [N-1:0]      hit;
    int                bad;
    blank_lz = blz;
    sb.push_back(model(v, blz));
    run_load(v, -1, nb, to);
    tests++;
    if (to || nb != BW + 1) begin
      fails++;
      $display("FAIL conv%0d_busy: got %0d cycles want %0d",
               v, nb, BW + 1);
    end
    capture(seen, hit, bad);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL conv%0d_sb: got empty want entry", v);
    end else begin
      e = sb.pop_front();
      tests++;
      if (overflow !== e.ovf) begin
        fails++;
        $display("FAIL conv%0d_ovf: got %b want %b",
                 v, overflow, e.ovf);
      end
      tests++;
      if (bad != 0 || hit !== 4'hF) begin
        fails++;
        $display("FAIL conv%0d_scan: got bad=%0d hit=%b want 0 1111",
                 v, bad, hit);
      end
      for (int i = 0; i < N; i++) begin
        tests++;
        if (seen[i] !== e.segs[i]) begin
          fails++;
          $display("FAIL conv%0d_dig%0d: got %b want %b",
                   v, i, seen[i], e.segs[i]);
        end
      end
    end
  endtask

  task automatic test_load_while_busy();
    exp_t              e;
    int                nb;
    bit                to;
    logic [N-1:0][6:0] seen;
    logic [N-1:0]      hit;
    int                bad;
    blank_lz = 1'b0;
    sb.push_back(model(42, 1'b0));
    run_load(42, 9999, nb, to);
    tests++;
    if (to || nb != BW + 1) begin
      fails++;
      $display("FAIL lwb_busy: got %0d cycles want %0d",
               nb, BW + 1);
    end
    capture(seen, hit, bad);
    e = sb.pop_front();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL lwb_idle: got busy=%b want 0", busy);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (seen[i] !== e.segs[i] || !hit[i]) begin
        fails++;
        $display("FAIL lwb_dig%0d: got %b want %b",
                 i, seen[i], e.segs[i]);
      end
    end
  endtask

  task automatic test_blink_dp();
    bit off_exp;
    bit off_got;
    @(negedge clk);
    blink_en = 1'b1;
    dp_mask  = 4'b0100;
    for (int k = 1; k <= 4 * BC; k++) begin
      @(negedge clk);
      off_exp = (((k - 1) / BC) % 2) == 1;
      off_got = (anode === 4'b1111);
      tests++;
      if (off_got != off_exp ||
          (!off_got && $countones(~anode) != 1)) begin
        fails++;
        $display("FAIL blink[%0d]: got anode=%b want off=%b",
                 k, anode, off_exp);
      end
      tests++;
      if (dp !== (anode === 4'b1011 ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL dp[%0d]: got %b with anode=%b",
                 k, dp, anode);
      end
    end
    @(negedge clk);
    blink_en = 1'b0;
    dp_mask  = '0;
  endtask

  task automatic test_reset_mid();
    exp_t              e;
    logic [N-1:0][6:0] seen;
    logic [N-1:0]      hit;
    int                bad;
    test_convert(12000, 1'b0);
    blank_lz = 1'b0;
    @(negedge clk);
    value = BW'(1234);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rmid_busy_pre: got %b want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL rmid_flags: got busy=%b ovf=%b want 0 0",
               busy, overflow);
    end
    tests++;
    if (anode !== 4'b1111 || seg !== 7'b1111111 ||
        dp !== 1'b1) begin
      fails++;
      $display("FAIL rmid_out: got %b %b %b want 1111 1111111 1",
               anode, seg, dp);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(model(0, 1'b0));
    capture(seen, hit, bad);
    e = sb.pop_front();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_idle: got busy=%b want 0", busy);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (seen[i] !== e.segs[i] || !hit[i]) begin
        fails++;
        $display("FAIL rmid_dig%0d: got %b want %b",
                 i, seen[i], e.segs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert(1234, 1'b0);
    test_convert(7, 1'b1);
    test_convert(0, 1'b1);
    test_convert(12000, 1'b0);
    test_load_while_busy();
    test_blink_dp();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller. It accepts a binary value, converts it to BCD with a sequential double-dabble engine, and time-multiplexes the digits onto a common-anode display. It adds three features to plain digit scanning: leading-zero blanking, per-digit decimal points, and a whole-display blink mode. It sits between the game/score logic and the board's anode/cathode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of display digits (1–8).
- BIN_W, 14, width of binary input value.
- DIGIT_CYCLES, 262144, clocks each digit stays active (2.6 ms at 100 MHz).
- BLINK_CYCLES, 50000000, clocks per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- load  in  1  pulse; capture value when busy=0.
- value  in  BIN_W  unsigned binary number to display.
- blank_lz  in  1  1 = blank leading zeros.
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of that digit; bit 0 = rightmost digit.
- blink_en  in  1  1 = blink the whole display.
- busy  out  1  conversion in progress.
- overflow  out  1  last loaded value > 10^NUM_DIGITS − 1.
- anode  out  NUM_DIGITS  active-low digit enables; bit 0 = rightmost (least significant) digit.
- seg  out  7  active-low cathodes; seg[6]=a … seg[0]=g.
- dp  out  1  active-low decimal point.

## Operation
- **Reset values:**
  - anode all 1, seg 7'b1111111, dp 1.
  - busy 0, overflow 0.
  - Display BCD register 0, scan index 0, all counters 0, blink phase on.
- **Load:**
  - load=1 with busy=0 captures value and starts the conversion.
  - load while busy=1 is ignored; no queuing.
- **Converter FSM** (IDLE → SHIFT → DONE → IDLE):
  - SHIFT runs exactly BIN_W iterations of add-3-then-shift over a 4·NUM_DIGITS + BIN_W bit register.
  - DONE copies the BCD into the display register and sets overflow.
  - overflow is set if any bit shifted out above 4·NUM_DIGITS was 1.
  - On overflow, every digit shows "-" (seg 7'b1111110).
  - The display register changes only in DONE, so the display never shows partial results.
- **Scan:**
  - A refresh counter counts 0..DIGIT_CYCLES−1.
  - At wrap, the scan index advances 0→1→…→NUM_DIGITS−1→0.
  - The active digit's anode bit is 0; all other bits are 1.
- **Decode:** BCD 0–9 map to 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100. Codes 10–15 show blank (1111111).
- **Leading-zero blank:**
  - Applies when blank_lz=1.
  - Digit i is blanked (seg all 1, its anode still asserted) if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- **dp:** dp = ~dp_mask[index].
- **Blink:**
  - When blink_en=1, a counter toggles the blink phase every BLINK_CYCLES clocks.
  - In the off phase, anode is all 1.
  - When blink_en=0, the blink counter is held at 0 and the phase is forced on.

## Timing
- busy rises the cycle after load is accepted.
- busy stays high for BIN_W+1 cycles (BIN_W SHIFT cycles + 1 DONE cycle).
- The display register and overflow update on the last busy cycle; busy=0 on the next cycle.
- load accepted at cycle t → new digits visible on the outputs at t+BIN_W+3 (includes the output register).
- anode/seg/dp are registered: they reflect the scan index, display register, and input controls sampled one cycle earlier.
- Scan period = NUM_DIGITS·DIGIT_CYCLES clocks; each digit is active exactly DIGIT_CYCLES consecutive clocks.
- The refresh counter and scan index run continuously and are unaffected by load or busy.
- Reset asserted mid-conversion aborts to IDLE, clears all state, and drives outputs to reset values immediately (asynchronously).

## Test plan
All scenarios use sim parameters NUM_DIGITS=4, BIN_W=14, DIGIT_CYCLES=4, BLINK_CYCLES=16.
- **Reset and scan:** release reset.
  - anode sequences 1110,1101,1011,0111, each held 4 clocks.
  - seg=0000001 on every digit (value 0, blank_lz=0).
- **Convert 1234:** load value=1234.
  - busy high 15 cycles.
  - Digits 3..0 show 1,2,3,4 (seg 1001111, 0010010, 0000110, 1001100).
  - overflow=0.
- **Leading-zero blank and overflow:**
  - value=7 with blank_lz=1 → digits 3..1 seg 1111111, digit 0 seg 0001111.
  - value=0 → digit 0 shows 0000001.
  - value=12000 → overflow=1, all digits 1111110.
- **Load while busy:** load 42, then load 9999 two cycles later → display shows 0042; 9999 is ignored.
- **Blink and dp:** blink_en=1, dp_mask=0100.
  - anode is all 1 for 16 clocks, active for 16, alternating.
  - dp=0 only while anode=1011.
- **Reset mid-conversion:** assert reset 5 cycles into SHIFT → busy=0 and outputs return to reset values the same cycle; the display register stays 0.
